decode_queue: RTL

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue.sv | 107 ++++++++++
 1 files changed

// File: rtl/decode_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decode_queue : circular instruction queue, 8-wide fetch in / decode out  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module decode_queue #(
   parameter int unsigned DEPTH     = 16,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush_i,
   input  logic                    enq_valid_i,
   input  logic [3:0]              enq_count_i,
   input  logic [7:0][31:0]        enq_instr_i,
   input  logic [7:0][63:0]        enq_pc_i,
   output logic                    enq_ready_o,
   input  logic                    deq_ready_i,
   output logic [7:0]              deq_valid_o,
   output logic [7:0][31:0]        deq_instr_o,
   output logic [7:0][63:0]        deq_pc_o,
   output logic [$clog2(DEPTH):0]  occupancy_o
);

   localparam int unsigned PW    = $clog2(DEPTH);
   localparam int unsigned OW    = PW + 1;
   localparam int unsigned WIDTH = 8;
   localparam logic [OW-1:0] READY_MAX = OW'(DEPTH - WIDTH);
   localparam logic [OW-1:0] OCC_MAX   = OW'(DEPTH);

   logic [31:0]   instr_mem_q [DEPTH];
   logic [63:0]   pc_mem_q    [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [OW-1:0] occ_q, occ_d;

   logic          count_ok;
   logic          enq_fire;
   logic [OW-1:0] enq_n;
   logic [OW-1:0] deq_n;

   // Readiness reserves room for a full bundle against registered occupancy only.
   always_comb begin
      count_ok    = (enq_count_i != 4'd0) && (enq_count_i <= 4'd8);
      enq_ready_o = (occ_q <= READY_MAX);
      enq_fire    = enq_valid_i && enq_ready_o && count_ok && !flush_i;
      enq_n       = enq_fire ? OW'(enq_count_i) : '0;
      if (!deq_ready_i) begin
         deq_n = '0;
      end else if (occ_q > OW'(WIDTH)) begin
         deq_n = OW'(WIDTH);
      end else begin
         deq_n = occ_q;
      end
   end

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (flush_i) begin
         head_d = '0;
         tail_d = '0;
         occ_d  = '0;
      end else begin
         head_d = head_q + deq_n[PW-1:0];
         tail_d = tail_q + enq_n[PW-1:0];
         occ_d  = occ_q + enq_n - deq_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   // Storage is deliberately left out of reset; validity comes from occupancy.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (enq_fire && (4'(i) < enq_count_i)) begin
            instr_mem_q[tail_q + PW'(i)] <= enq_instr_i[i];
            pc_mem_q[tail_q + PW'(i)]    <= enq_pc_i[i];
         end
      end
   end

   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_slot
      logic [PW-1:0] rd_idx;
      assign rd_idx          = head_q + PW'(i);
      assign deq_valid_o[i]  = (occ_q > OW'(i));
      assign deq_instr_o[i]  = deq_valid_o[i] ? instr_mem_q[rd_idx] : NOP_INSTR;
      assign deq_pc_o[i]     = deq_valid_o[i] ? pc_mem_q[rd_idx] : 64'd0;
   end

   assign occupancy_o = occ_q;

   a_occ_bound : assert property (@(posedge clk) disable iff (!rst_n) occ_q <= OCC_MAX);

endmodule
`default_nettype wire
